// File: rtl/spi_cmd_wb_master.sv
// Decodes SPI command bytes (read/write, absolute or auto-increment address) and
// issues single Wishbone B4 pipelined transactions, returning read bytes to the SPI side.
module spi_cmd_wb_master #(
    parameter int ADDR_WIDTH     = 17,
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  wb_clock_i,
    input  logic                  wb_reset_ni,
    input  logic [7:0]            rx_data_i,
    input  logic                  rx_valid_i,
    input  logic                  frame_start_i,
    output logic [7:0]            tx_data_o,
    output logic                  tx_valid_o,
    output logic                  busy_o,
    output logic                  err_o,
    output logic [ADDR_WIDTH-1:0] wbm_addr_o,
    output logic [DATA_WIDTH-1:0] wbm_data_o,
    input  logic [DATA_WIDTH-1:0] wbm_data_i,
    output logic                  wbm_we_o,
    output logic                  wbm_cycle_o,
    output logic                  wbm_strobe_o,
    input  logic                  wbm_stall_i,
    input  logic                  wbm_ack_i
);

    typedef enum logic [1:0] {P_CMD, P_ADDR_HI, P_ADDR_LO, P_DATA} pstate_t;
    typedef enum logic [1:0] {B_IDLE, B_REQ, B_WAIT_ACK} bstate_t;

    pstate_t               pstate_q, pstate_d, ps;
    bstate_t               bstate_q, bstate_d;
    logic                  wr_q, wr_d, at_q, at_d, a16_q, a16_d;
    logic [7:0]            hi_q, hi_d, lo_q, lo_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  we_q, we_d, cyc_q, cyc_d, stb_q, stb_d;
    logic [7:0]            cnt_q, cnt_d;
    logic [7:0]            tx_data_q, tx_data_d;
    logic                  tx_valid_q, tx_valid_d, err_q, err_d;

    logic                  issue, issue_we;
    logic [ADDR_WIDTH-1:0] issue_addr;
    logic [DATA_WIDTH-1:0] issue_data;

    always_comb begin
        wr_d       = wr_q;
        at_d       = at_q;
        a16_d      = a16_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        we_d       = we_q;
        cyc_d      = cyc_q;
        stb_d      = stb_q;
        cnt_d      = cnt_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = 1'b0;
        err_d      = err_q;
        bstate_d   = bstate_q;
        issue      = 1'b0;
        issue_we   = 1'b0;
        issue_addr = '0;
        issue_data = '0;

        // A frame start resyncs the parser before any byte arriving with it is decoded
        ps       = frame_start_i ? P_CMD : pstate_q;
        pstate_d = ps;
        if (frame_start_i)
            err_d = 1'b0;

        if (rx_valid_i) begin
            if (cyc_q) begin
                err_d = 1'b1;
            end else begin
                case (ps)
                    P_CMD: begin
                        case (rx_data_i[7:4])
                            4'h8: begin wr_d = 1'b1; at_d = 1'b1; a16_d = rx_data_i[0]; pstate_d = P_ADDR_HI; end
                            4'h3: begin wr_d = 1'b0; at_d = 1'b1; a16_d = rx_data_i[0]; pstate_d = P_ADDR_HI; end
                            4'h4: begin wr_d = 1'b1; at_d = 1'b0; pstate_d = P_DATA; end
                            4'h2: begin issue = 1'b1; issue_addr = addr_q + 1'b1; end
                            default: err_d = 1'b1;
                        endcase
                    end
                    P_ADDR_HI: begin
                        hi_d     = rx_data_i;
                        pstate_d = P_ADDR_LO;
                    end
                    P_ADDR_LO: begin
                        lo_d = rx_data_i;
                        if (wr_q) begin
                            pstate_d = P_DATA;
                        end else begin
                            issue      = 1'b1;
                            issue_addr = ADDR_WIDTH'({a16_q, hi_q, rx_data_i});
                            pstate_d   = P_CMD;
                        end
                    end
                    default: begin
                        issue      = 1'b1;
                        issue_we   = 1'b1;
                        issue_data = DATA_WIDTH'(rx_data_i);
                        issue_addr = at_q ? ADDR_WIDTH'({a16_q, hi_q, lo_q}) : addr_q + 1'b1;
                        pstate_d   = P_CMD;
                    end
                endcase
            end
        end

        case (bstate_q)
            B_IDLE: begin
                if (issue) begin
                    addr_d   = issue_addr;
                    wdata_d  = issue_we ? issue_data : wdata_q;
                    we_d     = issue_we;
                    cyc_d    = 1'b1;
                    stb_d    = 1'b1;
                    cnt_d    = 8'd0;
                    bstate_d = B_REQ;
                end
            end
            default: begin
                if (wbm_ack_i) begin
                    cyc_d    = 1'b0;
                    stb_d    = 1'b0;
                    bstate_d = B_IDLE;
                    if (!we_q) begin
                        tx_data_d  = wbm_data_i[7:0];
                        tx_valid_d = 1'b1;
                    end
                end else if (cnt_q == 8'(TIMEOUT_CYCLES - 1)) begin
                    cyc_d    = 1'b0;
                    stb_d    = 1'b0;
                    err_d    = 1'b1;
                    bstate_d = B_IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                    if (bstate_q == B_REQ && !wbm_stall_i) begin
                        stb_d    = 1'b0;
                        bstate_d = B_WAIT_ACK;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge wb_clock_i or negedge wb_reset_ni) begin
        if (!wb_reset_ni) begin
            pstate_q   <= P_CMD;
            bstate_q   <= B_IDLE;
            wr_q       <= 1'b0;
            at_q       <= 1'b0;
            a16_q      <= 1'b0;
            hi_q       <= 8'd0;
            lo_q       <= 8'd0;
            addr_q     <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            cyc_q      <= 1'b0;
            stb_q      <= 1'b0;
            cnt_q      <= 8'd0;
            tx_data_q  <= 8'd0;
            tx_valid_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            pstate_q   <= pstate_d;
            bstate_q   <= bstate_d;
            wr_q       <= wr_d;
            at_q       <= at_d;
            a16_q      <= a16_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            we_q       <= we_d;
            cyc_q      <= cyc_d;
            stb_q      <= stb_d;
            cnt_q      <= cnt_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            err_q      <= err_d;
        end
    end

    assign tx_data_o    = tx_data_q;
    assign tx_valid_o   = tx_valid_q;
    assign busy_o       = cyc_q;
    assign err_o        = err_q;
    assign wbm_addr_o   = addr_q;
    assign wbm_data_o   = wdata_q;
    assign wbm_we_o     = we_q;
    assign wbm_cycle_o  = cyc_q;
    assign wbm_strobe_o = stb_q;

endmodule

// File: tb/tb_spi_cmd_wb_master.sv
// Directed bench for spi_cmd_wb_master: command decode, auto-increment wrap, stall,
// timeout, overrun, bad opcode, frame resync and asynchronous reset.
module tb_spi_cmd_wb_master;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rx_data = 8'd0;
    logic        rx_valid = 1'b0;
    logic        frame_start = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        busy;
    logic        err;
    logic [16:0] wbm_addr;
    logic [7:0]  wbm_wdata;
    logic [7:0]  wbm_rdata = 8'd0;
    logic        wbm_we;
    logic        wbm_cyc;
    logic        wbm_stb;
    logic        wbm_stall = 1'b0;
    logic        wbm_ack = 1'b0;

    int n_assert = 0;
    int n_fail   = 0;

    spi_cmd_wb_master #(.ADDR_WIDTH(17), .DATA_WIDTH(8), .TIMEOUT_CYCLES(255)) dut (
        .wb_clock_i    (clk),
        .wb_reset_ni   (rst_n),
        .rx_data_i     (rx_data),
        .rx_valid_i    (rx_valid),
        .frame_start_i (frame_start),
        .tx_data_o     (tx_data),
        .tx_valid_o    (tx_valid),
        .busy_o        (busy),
        .err_o         (err),
        .wbm_addr_o    (wbm_addr),
        .wbm_data_o    (wbm_wdata),
        .wbm_data_i    (wbm_rdata),
        .wbm_we_o      (wbm_we),
        .wbm_cycle_o   (wbm_cyc),
        .wbm_strobe_o  (wbm_stb),
        .wbm_stall_i   (wbm_stall),
        .wbm_ack_i     (wbm_ack)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        $display("rx byte %02h -> cyc=%0b stb=%0b addr=%05h err=%0b", b, wbm_cyc, wbm_stb, wbm_addr, err);
    endtask

    task automatic ack_now(input logic [7:0] rd);
        wbm_rdata = rd;
        wbm_ack   = 1'b1;
        tick();
        wbm_ack   = 1'b0;
    endtask

    initial begin
        int cyc_cnt;

        // Reset values
        #12;
        chk("rst_cyc", wbm_cyc, 1'b0);
        chk("rst_stb", wbm_stb, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_txv", tx_valid, 1'b0);
        chk("rst_addr", wbm_addr, 17'h0);
        tick();
        rst_n = 1'b1;
        tick();

        // WRITE_AT 0x12345 <= 0xA5
        send_byte(8'h81); send_byte(8'h23); send_byte(8'h45); send_byte(8'hA5);
        chk("wr_cyc", wbm_cyc, 1'b1);
        chk("wr_stb", wbm_stb, 1'b1);
        chk("wr_busy", busy, 1'b1);
        chk("wr_we", wbm_we, 1'b1);
        chk("wr_addr", wbm_addr, 17'h12345);
        chk("wr_data", wbm_wdata, 8'hA5);
        tick();
        chk("wr_stb_drop", wbm_stb, 1'b0);
        chk("wr_cyc_hold", wbm_cyc, 1'b1);
        ack_now(8'h00);
        chk("wr_cyc_end", wbm_cyc, 1'b0);
        chk("wr_busy_end", busy, 1'b0);
        chk("wr_no_txv", tx_valid, 1'b0);
        tick();
        chk("wr_no_txv2", tx_valid, 1'b0);

        // READ_AT 0x0FFFF then READ_NEXT -> 0x10000
        send_byte(8'h30); send_byte(8'hFF); send_byte(8'hFF);
        chk("rd1_addr", wbm_addr, 17'h0FFFF);
        chk("rd1_we", wbm_we, 1'b0);
        tick();
        ack_now(8'h11);
        chk("rd1_cyc_end", wbm_cyc, 1'b0);
        chk("rd1_txv", tx_valid, 1'b1);
        chk("rd1_txd", tx_data, 8'h11);
        tick();
        chk("rd1_txv_once", tx_valid, 1'b0);
        send_byte(8'h20);
        chk("rd2_addr", wbm_addr, 17'h10000);
        chk("rd2_stb", wbm_stb, 1'b1);
        ack_now(8'h22);
        chk("rd2_cyc_end", wbm_cyc, 1'b0);
        chk("rd2_stb_end", wbm_stb, 1'b0);
        chk("rd2_txv", tx_valid, 1'b1);
        chk("rd2_txd", tx_data, 8'h22);
        tick();
        chk("rd2_txv_once", tx_valid, 1'b0);

        // Wrap: READ_AT 0x1FFFF then WRITE_NEXT -> 0x00000
        send_byte(8'h31); send_byte(8'hFF); send_byte(8'hFF);
        chk("wrap_rd_addr", wbm_addr, 17'h1FFFF);
        ack_now(8'h77);
        chk("wrap_rd_txd", tx_data, 8'h77);
        send_byte(8'h40); send_byte(8'h5A);
        chk("wrap_addr", wbm_addr, 17'h00000);
        chk("wrap_data", wbm_wdata, 8'h5A);
        chk("wrap_we", wbm_we, 1'b1);
        ack_now(8'h00);
        chk("wrap_cyc_end", wbm_cyc, 1'b0);

        // Stall held 4 cycles on a write to 0x10010
        send_byte(8'h81); send_byte(8'h00); send_byte(8'h10);
        wbm_stall = 1'b1;
        send_byte(8'h3C);
        for (int i = 0; i < 4; i++) begin
            chk("stall_stb", wbm_stb, 1'b1);
            chk("stall_addr", wbm_addr, 17'h10010);
            chk("stall_data", wbm_wdata, 8'h3C);
            tick();
        end
        chk("stall_stb5", wbm_stb, 1'b1);
        wbm_stall = 1'b0;
        tick();
        chk("stall_stb_drop", wbm_stb, 1'b0);
        chk("stall_cyc_hold", wbm_cyc, 1'b1);
        ack_now(8'h00);
        chk("stall_cyc_end", wbm_cyc, 1'b0);

        // Timeout on a read of 0x00000 that is never acked
        send_byte(8'h30); send_byte(8'h00); send_byte(8'h00);
        cyc_cnt = 0;
        while (wbm_cyc === 1'b1 && cyc_cnt < 300) begin
            tick();
            cyc_cnt++;
            chk("to_no_txv", tx_valid, 1'b0);
        end
        chk("to_cycles", cyc_cnt, 255);
        chk("to_err", err, 1'b1);
        chk("to_busy", busy, 1'b0);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        chk("fs_err_clr", err, 1'b0);

        // Overrun: second byte while busy is dropped
        send_byte(8'h20);
        chk("ovr_addr", wbm_addr, 17'h00001);
        chk("ovr_err0", err, 1'b0);
        send_byte(8'h55);
        chk("ovr_err", err, 1'b1);
        chk("ovr_busy", busy, 1'b1);
        ack_now(8'h99);
        chk("ovr_txd", tx_data, 8'h99);
        send_byte(8'h20);
        chk("ovr_next_addr", wbm_addr, 17'h00002);
        ack_now(8'h00);

        // Bad opcode leaves parser in CMD
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        send_byte(8'h70);
        chk("bad_err", err, 1'b1);
        chk("bad_cyc", wbm_cyc, 1'b0);
        send_byte(8'h20);
        chk("bad_then_cyc", wbm_cyc, 1'b1);
        chk("bad_then_addr", wbm_addr, 17'h00003);
        tick();
        chk("bad_wait_ack", wbm_stb, 1'b0);

        // Asynchronous reset during WAIT_ACK
        #2 rst_n = 1'b0;
        #1;
        chk("arst_cyc", wbm_cyc, 1'b0);
        chk("arst_stb", wbm_stb, 1'b0);
        chk("arst_busy", busy, 1'b0);
        chk("arst_err", err, 1'b0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("arst_addr", wbm_addr, 17'h0);

        // Frame start and a byte together: mid-command parser resyncs, byte is a CMD
        send_byte(8'h81);
        frame_start = 1'b1;
        send_byte(8'h20);
        frame_start = 1'b0;
        chk("fsrx_cyc", wbm_cyc, 1'b1);
        chk("fsrx_addr", wbm_addr, 17'h00001);
        chk("fsrx_we", wbm_we, 1'b0);
        ack_now(8'h3D);
        chk("fsrx_txd", tx_data, 8'h3D);
        chk("fsrx_txv", tx_valid, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
